// File: rtl/ray_column_buffer_pkg.sv
// Shared types for the ray column buffer: DDA beat layout, stored column record,
// write-side FSM states.
package ray_column_pkg;

    localparam int DDA_OUT_W = 38;
    localparam int HCOUNT_W  = 9;
    localparam int LH_W      = 8;
    localparam int MAP_W     = 4;
    localparam int WALLX_W   = 16;
    localparam int COL_W     = LH_W + 1 + MAP_W + WALLX_W;
    localparam int RAM_AW    = 10;

    typedef struct packed {
        logic [LH_W-1:0]    lineHeight;
        logic               wallType;
        logic [MAP_W-1:0]   mapData;
        logic [WALLX_W-1:0] wallX;
    } column_t;

    typedef struct packed {
        logic [HCOUNT_W-1:0] hcount;
        column_t             col;
    } ray_beat_t;

    typedef enum logic {FILL, FULL} wr_state_t;

    function automatic ray_beat_t unpack_beat(input logic [DDA_OUT_W-1:0] beat);
        return ray_beat_t'(beat);
    endfunction

endpackage

// File: rtl/ray_column_buffer_col_bank_ram.sv
// Two-bank column store: one write port, one read port with registered output.
module col_bank_ram
    import ray_column_pkg::*;
#(
    parameter int DEPTH = 640
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [RAM_AW-1:0] waddr_i,
    input  column_t           wdata_i,
    input  logic              re_i,
    input  logic [RAM_AW-1:0] raddr_i,
    output column_t           rdata_o
);

    column_t mem [DEPTH];
    column_t rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ray_column_buffer.sv
// Double-buffered per-column ray store with 2-cycle pixel lookup.
// Optional counters under RAY_COLUMN_BUFFER_STATS_EN.  States: FILL | accepting rays; FULL | frame complete, awaiting frame_start_in.
module ray_column_buffer
    import ray_column_pkg::*;
#(
    parameter int SCREEN_WIDTH  = 320,
    parameter int SCREEN_HEIGHT = 180
) (
    input  logic                 pixel_clk_in,
    input  logic                 rst_in,
    input  logic                 s_tvalid,
    input  logic [DDA_OUT_W-1:0] s_tdata,
    input  logic                 s_tlast,
    output logic                 s_tready,
    input  logic                 frame_start_in,
    input  logic                 rd_req_in,
    input  logic [8:0]           hcount_in,
    input  logic [7:0]           vcount_in,
    output logic                 rd_valid_out,
    output logic                 frame_valid_out,
    output logic                 in_wall_out,
    output logic                 wallType_out,
    output logic [3:0]           mapData_out,
    output logic [15:0]          wallX_out,
`ifdef RAY_COLUMN_BUFFER_STATS_EN
    output logic [15:0]          frames_swapped_out,
    output logic [15:0]          stall_cycles_out,
`endif
    output logic                 hcount_err_out
);

    localparam logic [8:0] SW9 = 9'(SCREEN_WIDTH);
    localparam logic [8:0] SH9 = 9'(SCREEN_HEIGHT);

    function automatic logic [RAM_AW-1:0] lin_addr(input logic bank, input logic [8:0] col);
        return bank ? (RAM_AW'(col) + RAM_AW'(SCREEN_WIDTH)) : RAM_AW'(col);
    endfunction

    wr_state_t state_q, state_d;
    logic      wr_bank_q, rd_bank_q, frame_valid_q, err_q;
    logic      swap, xfer, col_ok;
    ray_beat_t beat;

    assign beat     = unpack_beat(s_tdata);
    // Held low during reset so every output reads 0 while rst_in is high.
    assign s_tready = (state_q == FILL) && !rst_in;
    assign xfer     = s_tvalid && s_tready;
    assign col_ok   = beat.hcount < SW9;

    always_comb begin
        state_d = state_q;
        swap    = 1'b0;
        case (state_q)
            FILL: if (xfer && s_tlast) state_d = FULL;
            FULL: if (frame_start_in) begin
                swap    = 1'b1;
                state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= FILL;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b1;
            frame_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q <= state_d;
            if (swap) begin
                rd_bank_q     <= wr_bank_q;
                wr_bank_q     <= ~wr_bank_q;
                frame_valid_q <= 1'b1;
            end
            if (xfer && !col_ok) begin
                err_q <= 1'b1;
            end
        end
    end

    logic    rd_col_ok;
    column_t ram_rdata;

    assign rd_col_ok = hcount_in < SW9;

    col_bank_ram #(.DEPTH(2 * SCREEN_WIDTH)) u_ram (
        .clk_i   (pixel_clk_in),
        .we_i    (xfer && col_ok),
        .waddr_i (lin_addr(wr_bank_q, beat.hcount)),
        .wdata_i (beat.col),
        .re_i    (rd_req_in && rd_col_ok),
        .raddr_i (lin_addr(rd_bank_q, hcount_in)),
        .rdata_o (ram_rdata)
    );

    logic       rd_v1_q, oob1_q, fv1_q;
    logic [7:0] vcount1_q;

    // Bank and frame-valid are sampled with the request, so a swap mid-read is harmless.
    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            rd_v1_q   <= 1'b0;
            oob1_q    <= 1'b0;
            fv1_q     <= 1'b0;
            vcount1_q <= '0;
        end else begin
            rd_v1_q   <= rd_req_in;
            oob1_q    <= !rd_col_ok;
            fv1_q     <= frame_valid_q;
            vcount1_q <= vcount_in;
        end
    end

    logic [8:0] lh9, start_c, end_c, v9;
    logic       in_wall_c;

    always_comb begin
        lh9 = {1'b0, ram_rdata.lineHeight};
        v9  = {1'b0, vcount1_q};
        if (lh9 < SH9) begin
            start_c = (SH9 - lh9) >> 1;
            end_c   = start_c + lh9 - 9'd1;
        end else begin
            start_c = '0;
            end_c   = SH9 - 9'd1;
        end
        in_wall_c = (lh9 != '0) && (v9 >= start_c) && (v9 <= end_c) && fv1_q;
    end

    logic        rd_valid_q, in_wall_q, wall_type_q;
    logic [3:0]  map_data_q;
    logic [15:0] wall_x_q;

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            rd_valid_q  <= 1'b0;
            in_wall_q   <= 1'b0;
            wall_type_q <= 1'b0;
            map_data_q  <= '0;
            wall_x_q    <= '0;
        end else begin
            rd_valid_q <= rd_v1_q;
            if (rd_v1_q) begin
                if (oob1_q) begin
                    in_wall_q   <= 1'b0;
                    wall_type_q <= 1'b0;
                    map_data_q  <= '0;
                    wall_x_q    <= '0;
                end else begin
                    in_wall_q   <= in_wall_c;
                    wall_type_q <= ram_rdata.wallType;
                    map_data_q  <= ram_rdata.mapData;
                    wall_x_q    <= ram_rdata.wallX;
                end
            end
        end
    end

    assign rd_valid_out    = rd_valid_q;
    assign frame_valid_out = frame_valid_q;
    assign in_wall_out     = in_wall_q;
    assign wallType_out    = wall_type_q;
    assign mapData_out     = map_data_q;
    assign wallX_out       = wall_x_q;
    assign hcount_err_out  = err_q;

`ifdef RAY_COLUMN_BUFFER_STATS_EN
    logic [15:0] frames_q, stall_q;

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            frames_q <= '0;
            stall_q  <= '0;
        end else begin
            if (swap) begin
                frames_q <= frames_q + 16'd1;
                stall_q  <= '0;
            end else if (s_tvalid && !s_tready && stall_q != 16'hFFFF) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    assign frames_swapped_out = frames_q;
    assign stall_cycles_out   = stall_q;
`endif

endmodule

// File: tb/tb_ray_column_buffer.sv
// Directed bench for ray_column_buffer: a bank model feeds an expected-result queue
// that is popped when each lookup completes.
module tb_ray_column_buffer;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic        s_tvalid = 1'b0;
    logic [37:0] s_tdata = '0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic        frame_start_in = 1'b0;
    logic        rd_req_in = 1'b0;
    logic [8:0]  hcount_in = '0;
    logic [7:0]  vcount_in = '0;
    logic        rd_valid_out, frame_valid_out, in_wall_out, wallType_out, hcount_err_out;
    logic [3:0]  mapData_out;
    logic [15:0] wallX_out;

    always #5 clk = ~clk;

    ray_column_buffer dut (
        .pixel_clk_in   (clk),
        .rst_in         (rst_in),
        .s_tvalid       (s_tvalid),
        .s_tdata        (s_tdata),
        .s_tlast        (s_tlast),
        .s_tready       (s_tready),
        .frame_start_in (frame_start_in),
        .rd_req_in      (rd_req_in),
        .hcount_in      (hcount_in),
        .vcount_in      (vcount_in),
        .rd_valid_out   (rd_valid_out),
        .frame_valid_out(frame_valid_out),
        .in_wall_out    (in_wall_out),
        .wallType_out   (wallType_out),
        .mapData_out    (mapData_out),
        .wallX_out      (wallX_out),
        .hcount_err_out (hcount_err_out)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        iw;
        logic        wt;
        logic [3:0]  md;
        logic [15:0] wx;
        logic        cd;
    } exp_t;

    exp_t        exp_q[$];
    logic [28:0] mem_m [1024];
    logic        wr_m  [1024];
    logic        wr_bank_m = 1'b0, rd_bank_m = 1'b1, fv_m = 1'b0, full_m = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_wall(input int lh, input int v);
        int s, e;
        if (lh == 0) return 1'b0;
        if (lh < 180) begin
            s = (180 - lh) / 2;
            e = s + lh - 1;
        end else begin
            s = 0;
            e = 179;
        end
        return (v >= s) && (v <= e);
    endfunction

    task automatic send_beat(input int h, input int lh, input logic wt, input logic [3:0] md,
                             input logic [15:0] wx, input logic last, input logic fs);
        int idx;
        chk("tready_before_beat", {31'd0, s_tready}, 32'd1);
        s_tvalid       = 1'b1;
        s_tdata        = {9'(h), 8'(lh), wt, md, wx};
        s_tlast        = last;
        frame_start_in = fs;
        @(posedge clk); #1;
        s_tvalid       = 1'b0;
        s_tlast        = 1'b0;
        frame_start_in = 1'b0;
        if (h < 320) begin
            idx        = (wr_bank_m ? 512 : 0) + h;
            mem_m[idx] = {8'(lh), wt, md, wx};
            wr_m[idx]  = 1'b1;
        end
        if (last) full_m = 1'b1;
    endtask

    task automatic pulse_fs();
        frame_start_in = 1'b1;
        @(posedge clk); #1;
        frame_start_in = 1'b0;
        if (full_m) begin
            rd_bank_m = wr_bank_m;
            wr_bank_m = ~wr_bank_m;
            fv_m      = 1'b1;
            full_m    = 1'b0;
        end
    endtask

    task automatic do_read(input int h, input int v, input string tag);
        exp_t        e, got;
        int          idx, n;
        logic [28:0] col;
        if (h >= 320) begin
            e = '{iw: 1'b0, wt: 1'b0, md: 4'd0, wx: 16'd0, cd: 1'b1};
        end else begin
            idx  = (rd_bank_m ? 512 : 0) + h;
            col  = mem_m[idx];
            e.cd = wr_m[idx];
            e.iw = (fv_m && wr_m[idx]) ? exp_wall(int'(col[28:21]), v) : 1'b0;
            e.wt = col[20];
            e.md = col[19:16];
            e.wx = col[15:0];
        end
        exp_q.push_back(e);
        rd_req_in = 1'b1;
        hcount_in = 9'(h);
        vcount_in = 8'(v);
        @(posedge clk); #1;
        rd_req_in = 1'b0;
        chk({tag, "_early"}, {31'd0, rd_valid_out}, 32'd0);
        @(posedge clk); #1;
        n = 0;
        while (!rd_valid_out && n < 4) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_rd_valid"}, {31'd0, rd_valid_out}, 32'd1);
        got = exp_q.pop_front();
        chk({tag, "_in_wall"}, {31'd0, in_wall_out}, {31'd0, got.iw});
        if (got.cd) begin
            chk({tag, "_wallType"}, {31'd0, wallType_out}, {31'd0, got.wt});
            chk({tag, "_mapData"}, {28'd0, mapData_out}, {28'd0, got.md});
            chk({tag, "_wallX"}, {16'd0, wallX_out}, {16'd0, got.wx});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) wr_m[i] = 1'b0;

        // Reset: everything reads 0 while held
        #12;
        chk("rst_tready", {31'd0, s_tready}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid_out}, 32'd0);
        chk("rst_frame_valid", {31'd0, frame_valid_out}, 32'd0);
        chk("rst_err", {31'd0, hcount_err_out}, 32'd0);
        chk("rst_in_wall", {31'd0, in_wall_out}, 32'd0);
        @(posedge clk); #1;
        rst_in = 1'b0;
        #1;
        chk("post_rst_tready", {31'd0, s_tready}, 32'd1);

        // frame_start during FILL is ignored; lookups before any swap never hit a wall
        pulse_fs();
        chk("fs_in_fill_ignored", {31'd0, frame_valid_out}, 32'd0);
        do_read(10, 60, "pre_swap");

        // Frame 1: all columns, lh=60
        for (int i = 0; i < 320; i++) begin
            send_beat(i, 60, i[0], 4'(i), 16'(i * 7), i == 319, 1'b0);
        end
        chk("full_tready", {31'd0, s_tready}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("full_tready_held", {31'd0, s_tready}, 32'd0);
        chk("full_no_frame_valid", {31'd0, frame_valid_out}, 32'd0);
        pulse_fs();
        chk("swap1_tready", {31'd0, s_tready}, 32'd1);
        chk("swap1_frame_valid", {31'd0, frame_valid_out}, 32'd1);
        do_read(10, 60, "f1_c10_v60");
        do_read(10, 59, "f1_c10_v59");
        do_read(10, 119, "f1_c10_v119");
        do_read(10, 120, "f1_c10_v120");
        do_read(317, 90, "f1_c317_v90");

        // Frame 2: clamp, zero height, duplicate column, bad column, tlast with frame_start
        send_beat(5, 200, 1'b1, 4'hA, 16'hBEEF, 1'b0, 1'b0);
        send_beat(6, 0, 1'b0, 4'h3, 16'h1234, 1'b0, 1'b0);
        send_beat(7, 60, 1'b0, 4'h1, 16'h1111, 1'b0, 1'b0);
        send_beat(7, 100, 1'b1, 4'h2, 16'h2222, 1'b0, 1'b0);
        chk("err_before_bad", {31'd0, hcount_err_out}, 32'd0);
        send_beat(330, 60, 1'b1, 4'hF, 16'hFFFF, 1'b0, 1'b0);
        chk("err_after_bad", {31'd0, hcount_err_out}, 32'd1);
        send_beat(8, 10, 1'b0, 4'h5, 16'h5555, 1'b1, 1'b1);
        chk("tlast_fs_full", {31'd0, s_tready}, 32'd0);
        do_read(5, 0, "old_bank_c5_v0");
        do_read(5, 60, "old_bank_c5_v60");
        pulse_fs();
        chk("swap2_tready", {31'd0, s_tready}, 32'd1);
        do_read(5, 0, "clamp_v0");
        do_read(5, 179, "clamp_v179");
        do_read(6, 0, "lh0_v0");
        do_read(6, 90, "lh0_v90");
        do_read(6, 179, "lh0_v179");
        do_read(7, 45, "dup_v45");
        do_read(7, 30, "dup_v30");
        do_read(8, 85, "lh10_v85");
        do_read(8, 95, "lh10_v95");
        do_read(330, 60, "bad_col_read");
        chk("err_sticky", {31'd0, hcount_err_out}, 32'd1);

        // Reset asserted while a lookup result is on the outputs
        send_beat(1, 60, 1'b0, 4'h0, 16'h0001, 1'b0, 1'b0);
        rd_req_in = 1'b1;
        hcount_in = 9'd7;
        vcount_in = 8'd50;
        @(posedge clk); #1;
        rd_req_in = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_rd_valid", {31'd0, rd_valid_out}, 32'd1);
        chk("pre_rst_in_wall", {31'd0, in_wall_out}, 32'd1);
        rst_in = 1'b1;
        #1;
        chk("async_rst_rd_valid", {31'd0, rd_valid_out}, 32'd0);
        chk("async_rst_in_wall", {31'd0, in_wall_out}, 32'd0);
        chk("async_rst_frame_valid", {31'd0, frame_valid_out}, 32'd0);
        chk("async_rst_err", {31'd0, hcount_err_out}, 32'd0);
        chk("async_rst_tready", {31'd0, s_tready}, 32'd0);
        chk("async_rst_data", {11'd0, wallType_out, mapData_out, wallX_out}, 32'd0);
        @(posedge clk); #1;
        rst_in = 1'b0;
        wr_bank_m = 1'b0;
        rd_bank_m = 1'b1;
        fv_m      = 1'b0;
        full_m    = 1'b0;
        for (int i = 0; i < 1024; i++) wr_m[i] = 1'b0;
        #1;
        chk("post_rst2_tready", {31'd0, s_tready}, 32'd1);
        chk("post_rst2_frame_valid", {31'd0, frame_valid_out}, 32'd0);
        do_read(7, 50, "post_rst2_read");

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
